// File: rtl/icache_ctrl.sv
// Sequencing controller for the 2-way, 64-set, 8-byte-line instruction cache:
// tag/valid/LRU state, hit/miss decision, data-array control and AXI refill.
module icache_ctrl #(
  parameter logic [63:0] UNCACHED_LIMIT = 64'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [63:0] if_addr,
  input  logic        flush,
  output logic        if_rvalid,
  output logic [63:0] if_rdata,
  output logic        stallreq,
  output logic        arr_sram_e,
  output logic [63:0] arr_addr,
  output logic [1:0]  arr_hit,
  output logic        arr_lru,
  output logic        arr_cache,
  output logic        arr_refresh,
  output logic [63:0] arr_line,
  input  logic [63:0] arr_rdata,
  output logic        ar_valid,
  output logic [63:0] ar_addr,
  output logic [7:0]  ar_len,
  output logic [2:0]  ar_size,
  input  logic        ar_ready,
  input  logic        r_valid,
  input  logic        r_last,
  input  logic [63:0] r_data,
  output logic        r_ready
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOOKUP, S_MISS_AR, S_MISS_R, S_REFILL, S_UNC_AR, S_UNC_R
  } state_t;

  state_t       r_state;
  logic [54:0]  r_tag [2][64];
  logic [63:0]  r_vld [2];
  logic [63:0]  r_lru;
  logic [63:0]  r_line;

  logic [5:0]   w_idx;
  logic [54:0]  w_tag;
  logic         w_hit0;
  logic         w_hit1;
  logic [1:0]   w_hit_vec;
  logic         w_cacheable;
  logic         w_victim;
  logic         w_unused;

  assign w_idx       = if_addr[8:3];
  assign w_tag       = if_addr[63:9];
  assign w_hit0      = r_vld[0][w_idx] && (r_tag[0][w_idx] == w_tag);
  assign w_hit1      = r_vld[1][w_idx] && (r_tag[1][w_idx] == w_tag);
  // Both ways hitting is illegal; way0 wins so the select stays one-hot.
  assign w_hit_vec   = w_hit0 ? 2'b01 : (w_hit1 ? 2'b10 : 2'b00);
  assign w_cacheable = (if_addr >= UNCACHED_LIMIT);
  assign w_victim    = !r_vld[0][w_idx] ? 1'b0 :
                       (!r_vld[1][w_idx] ? 1'b1 : r_lru[w_idx]);
  assign w_unused    = r_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_vld[0] <= '0;
      r_vld[1] <= '0;
      r_lru    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (flush) begin
            r_vld[0] <= '0;
            r_vld[1] <= '0;
          end else if (if_req) begin
            if (!w_cacheable) begin
              r_state <= S_UNC_AR;
            end else if (w_hit0 || w_hit1) begin
              r_state      <= S_LOOKUP;
              r_lru[w_idx] <= w_hit0;
            end else begin
              r_state <= S_MISS_AR;
            end
          end
        end
        S_LOOKUP:  r_state <= S_IDLE;
        S_MISS_AR: if (ar_ready) r_state <= S_MISS_R;
        S_MISS_R: begin
          if (r_valid) begin
            r_line  <= r_data;
            r_state <= S_REFILL;
          end
        end
        S_REFILL: begin
          r_tag[w_victim][w_idx] <= w_tag;
          r_vld[w_victim][w_idx] <= 1'b1;
          r_lru[w_idx]           <= !r_lru[w_idx];
          r_state                <= S_IDLE;
        end
        S_UNC_AR:  if (ar_ready) r_state <= S_UNC_R;
        S_UNC_R:   if (r_valid) r_state <= S_IDLE;
        default:   r_state <= S_IDLE;
      endcase
    end
  end

  // The IDLE lookup must reach the array in the request cycle, so outputs
  // are decoded from the state rather than registered.
  always_comb begin
    if_rvalid   = 1'b0;
    if_rdata    = '0;
    arr_sram_e  = 1'b0;
    arr_addr    = '0;
    arr_hit     = 2'b00;
    arr_lru     = 1'b0;
    arr_cache   = 1'b0;
    arr_refresh = 1'b0;
    arr_line    = '0;
    ar_valid    = 1'b0;
    ar_addr     = '0;
    ar_len      = '0;
    ar_size     = '0;
    r_ready     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!flush && if_req && w_cacheable) begin
          arr_sram_e = 1'b1;
          arr_cache  = 1'b1;
          arr_hit    = w_hit_vec;
          arr_addr   = if_addr;
        end
      end
      S_LOOKUP: begin
        if_rvalid = 1'b1;
        if_rdata  = arr_rdata;
      end
      S_MISS_AR: begin
        ar_valid = 1'b1;
        ar_addr  = {if_addr[63:3], 3'b000};
        ar_size  = 3'd3;
      end
      S_MISS_R: r_ready = 1'b1;
      S_REFILL: begin
        arr_refresh = 1'b1;
        arr_cache   = 1'b1;
        arr_lru     = r_lru[w_idx];
        arr_hit     = w_victim ? 2'b10 : 2'b01;
        arr_line    = r_line;
        arr_addr    = if_addr;
        if_rvalid   = 1'b1;
        if_rdata    = r_line;
      end
      S_UNC_AR: begin
        ar_valid = 1'b1;
        ar_addr  = if_addr;
        ar_size  = 3'd3;
      end
      S_UNC_R: begin
        r_ready = 1'b1;
        if (r_valid) begin
          if_rvalid = 1'b1;
          if_rdata  = r_data;
        end
      end
      default: ;
    endcase
  end

  assign stallreq = if_req && !if_rvalid;

endmodule

// File: tb/tb_icache_ctrl.sv
// Self-checking bench for icache_ctrl: AXI slave with one cycle of read latency,
// a behavioural data array, and a scoreboard of expected fetch data.
module tb_icache_ctrl;

  logic        clk = 1'b0;
  logic        rst, if_req, flush;
  logic [63:0] if_addr;
  logic        if_rvalid, stallreq, arr_sram_e, arr_lru, arr_cache, arr_refresh;
  logic [63:0] if_rdata, arr_addr, arr_line, arr_rdata, ar_addr, r_data;
  logic [1:0]  arr_hit;
  logic        ar_valid, ar_ready, r_valid, r_last, r_ready;
  logic [7:0]  ar_len;
  logic [2:0]  ar_size;

  icache_ctrl dut (
    .clk(clk), .rst(rst), .if_req(if_req), .if_addr(if_addr), .flush(flush),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata), .stallreq(stallreq),
    .arr_sram_e(arr_sram_e), .arr_addr(arr_addr), .arr_hit(arr_hit),
    .arr_lru(arr_lru), .arr_cache(arr_cache), .arr_refresh(arr_refresh),
    .arr_line(arr_line), .arr_rdata(arr_rdata), .ar_valid(ar_valid),
    .ar_addr(ar_addr), .ar_len(ar_len), .ar_size(ar_size), .ar_ready(ar_ready),
    .r_valid(r_valid), .r_last(r_last), .r_data(r_data), .r_ready(r_ready)
  );

  always #5 clk = ~clk;

  localparam int K_HIT = 0, K_MISS = 1, K_UNC = 2;

  int n_tests = 0;
  int n_fail  = 0;
  logic [63:0] exp_q[$];

  int          sram_cnt, ref_cnt, ar_cnt, both_cnt, stall_err, ar_unstable;
  logic [1:0]  sram_hit, ref_hit;
  logic        ref_lru, ar_cache_c, ar_prev_v;
  logic [63:0] ar_addr_c, ar_prev_a;
  int          ar_wait_left;

  logic [63:0] arr0 [64];
  logic [63:0] arr1 [64];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] memv(input logic [63:0] a);
    if (a == 64'h8000_0000) return 64'hDEAD_BEEF_0000_0013;
    return {a[31:0] ^ 32'h5A5A_C3C3, a[31:0]};
  endfunction

  function automatic logic all_outs_or();
    return |{if_rvalid, if_rdata, stallreq, arr_sram_e, arr_addr, arr_hit, arr_lru,
             arr_cache, arr_refresh, arr_line, ar_valid, ar_addr, ar_len, ar_size, r_ready};
  endfunction

  // Monitor: event trackers plus scoreboard pop on every delivered fetch.
  initial begin
    ar_prev_v = 1'b0;
    ar_prev_a = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (arr_sram_e) begin sram_cnt++; sram_hit = arr_hit; end
        if (arr_refresh) begin ref_cnt++; ref_hit = arr_hit; ref_lru = arr_lru; end
        if (arr_refresh && arr_sram_e) both_cnt++;
        if (ar_valid && ar_prev_v && ar_addr !== ar_prev_a) ar_unstable++;
        ar_prev_v = ar_valid && !ar_ready;
        ar_prev_a = ar_addr;
        if (ar_valid && ar_ready) begin
          ar_cnt++;
          ar_addr_c  = ar_addr;
          ar_cache_c = arr_cache;
          if (ar_len !== 8'd0 || ar_size !== 3'd3) ar_unstable++;
        end
        if (if_req && !if_rvalid && !stallreq) stall_err++;
        if (if_rvalid) begin
          if (exp_q.size() == 0) chk("sb_empty", 64'(exp_q.size()), 64'd1);
          else chk("rdata", if_rdata, exp_q.pop_front());
        end
      end
    end
  end

  // AXI slave (one-cycle read latency) and the data-array model.
  initial begin
    logic s_rst, hs_ar, hs_r, ar_stall, s_sram, s_ref, pend;
    logic [1:0]  s_hit;
    logic [5:0]  s_idx;
    logic [63:0] s_line, s_araddr, pend_a;
    pend = 1'b0;
    pend_a = '0;
    forever begin
      @(negedge clk);
      s_rst = rst; hs_ar = ar_valid && ar_ready; hs_r = r_valid && r_ready;
      ar_stall = ar_valid && !ar_ready;
      s_sram = arr_sram_e; s_ref = arr_refresh; s_hit = arr_hit;
      s_idx = arr_addr[8:3]; s_line = arr_line; s_araddr = ar_addr;
      @(posedge clk); #1;
      if (s_ref) begin
        if (s_hit == 2'b10) arr1[s_idx] = s_line; else arr0[s_idx] = s_line;
      end
      if (s_sram) arr_rdata = (s_hit == 2'b10) ? arr1[s_idx] : arr0[s_idx];
      if (hs_r) r_valid = 1'b0;
      if (pend) begin r_valid = 1'b1; r_data = memv(pend_a); r_last = 1'b1; pend = 1'b0; end
      if (hs_ar) begin pend = 1'b1; pend_a = s_araddr; end
      if (ar_stall && ar_wait_left > 0) ar_wait_left--;
      ar_ready = (ar_wait_left == 0);
      if (s_rst) begin pend = 1'b0; r_valid = 1'b0; end
    end
  end

  task automatic fetch(input string tag, input logic [63:0] a, input int kind,
                       input logic [1:0] way, input int lat, input int arw);
    int n;
    bit got;
    @(posedge clk); #1;
    sram_cnt = 0; ref_cnt = 0; ar_cnt = 0; sram_hit = '0; ref_hit = '0;
    ar_addr_c = '0; ar_cache_c = 1'b1; ar_wait_left = arw;
    exp_q.push_back(memv(a));
    if_req = 1'b1;
    if_addr = a;
    n = 0;
    got = 1'b0;
    while (!got && n < 60) begin
      @(negedge clk); #1;
      if (if_rvalid) got = 1'b1;
      else begin @(posedge clk); #1; n++; end
    end
    chk({tag, "_done"}, 64'(got), 64'd1);
    @(posedge clk); #1;
    if_req = 1'b0;
    chk({tag, "_lat"}, 64'(n), 64'(lat));
    case (kind)
      K_HIT: begin
        chk({tag, "_ar_cnt"}, 64'(ar_cnt), 64'd0);
        chk({tag, "_ref_cnt"}, 64'(ref_cnt), 64'd0);
        chk({tag, "_sram_hit"}, 64'(sram_hit), 64'(way));
      end
      K_MISS: begin
        chk({tag, "_ar_cnt"}, 64'(ar_cnt), 64'd1);
        chk({tag, "_ar_addr"}, ar_addr_c, {a[63:3], 3'b000});
        chk({tag, "_ref_cnt"}, 64'(ref_cnt), 64'd1);
        chk({tag, "_ref_hit"}, 64'(ref_hit), 64'(way));
      end
      default: begin
        chk({tag, "_ar_cnt"}, 64'(ar_cnt), 64'd1);
        chk({tag, "_ar_addr"}, ar_addr_c, a);
        chk({tag, "_ar_cache"}, 64'(ar_cache_c), 64'd0);
        chk({tag, "_ref_cnt"}, 64'(ref_cnt), 64'd0);
        chk({tag, "_sram_cnt"}, 64'(sram_cnt), 64'd0);
      end
    endcase
    chk({tag, "_excl"}, 64'(both_cnt), 64'd0);
    chk({tag, "_stall"}, 64'(stall_err), 64'd0);
    chk({tag, "_ar_stable"}, 64'(ar_unstable), 64'd0);
  endtask

  initial begin
    rst = 1'b1; if_req = 1'b0; flush = 1'b0; if_addr = '0;
    ar_ready = 1'b1; r_valid = 1'b0; r_last = 1'b0; r_data = '0; arr_rdata = '0;
    ar_wait_left = 0; sram_cnt = 0; ref_cnt = 0; ar_cnt = 0; both_cnt = 0;
    stall_err = 0; ar_unstable = 0; ref_lru = 1'b0;
    for (int i = 0; i < 64; i++) begin arr0[i] = '0; arr1[i] = '0; end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_outs", 64'(all_outs_or()), 64'd0);

    fetch("cold",    64'h8000_0000, K_MISS, 2'b01, 4, 0);
    fetch("rehit",   64'h8000_0000, K_HIT,  2'b01, 1, 0);
    fetch("fill_w1", 64'h8000_0200, K_MISS, 2'b10, 4, 0);
    fetch("touch",   64'h8000_0000, K_HIT,  2'b01, 1, 0);
    fetch("evict",   64'h8000_0400, K_MISS, 2'b10, 4, 0);
    chk("evict_lru", 64'(ref_lru), 64'd1);
    fetch("still",   64'h8000_0000, K_HIT,  2'b01, 1, 0);
    fetch("w1_hit",  64'h8000_0400, K_HIT,  2'b10, 1, 0);
    fetch("unc",     64'h1000_0004, K_UNC,  2'b00, 3, 0);
    fetch("unc2",    64'h1000_0004, K_UNC,  2'b00, 3, 0);
    fetch("bp",      64'h8000_0808, K_MISS, 2'b01, 9, 5);

    // Reset while the refill read is outstanding.
    @(posedge clk); #1;
    ref_cnt = 0; ar_wait_left = 0;
    if_req = 1'b1; if_addr = 64'h8000_0800;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("abort_rready", 64'(r_ready), 64'd1);
    rst = 1'b1; if_req = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("abort_outs", 64'(all_outs_or()), 64'd0);
    repeat (3) @(posedge clk);
    chk("abort_refresh", 64'(ref_cnt), 64'd0);
    exp_q.delete();
    fetch("post_rst",  64'h8000_0000, K_MISS, 2'b01, 4, 0);
    fetch("post_rst2", 64'h8000_0808, K_MISS, 2'b01, 4, 0);
    fetch("post_fill", 64'h8000_0200, K_MISS, 2'b10, 4, 0);

    // Flush with a competing request: flush wins, then everything misses.
    @(posedge clk); #1;
    flush = 1'b1; if_req = 1'b1; if_addr = 64'h8000_0000;
    @(negedge clk);
    chk("flush_prio", 64'(arr_sram_e), 64'd0);
    @(posedge clk); #1;
    flush = 1'b0; if_req = 1'b0;
    @(negedge clk);
    chk("flush_outs", 64'(all_outs_or()), 64'd0);
    fetch("post_fl",  64'h8000_0000, K_MISS, 2'b01, 4, 0);
    fetch("post_fl2", 64'h8000_0808, K_MISS, 2'b01, 4, 0);
    fetch("post_fl3", 64'h8000_0200, K_MISS, 2'b10, 4, 0);
    fetch("post_hit", 64'h8000_0200, K_HIT,  2'b10, 1, 0);

    repeat (2) @(posedge clk);
    chk("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
